calc2_port_responder: RTL and testbench

Single-port responder for the calc2 request/response protocol: it accepts two-cycle tagged requests (cmd + operand1, then operand2), queues them, executes add/sub/shift, and returns one tagged response per request. It sits on the DUT side of one calc2 port and serves as the reference-model responder in the calc2 bench and as the per-port engine for the next calc2 top-level.

---
 rtl/calc2_port_responder_if.sv | 14 +
 rtl/calc2_port_responder.sv | 158 +++++++++++++++
 tb/tb_calc2_port_responder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/calc2_port_responder_if.sv
// calc2 request/response port: two-cycle tagged request in, one-cycle tagged response out.
interface calc2_port_responder_if;
  logic [3:0]  req_cmd_in;
  logic [31:0] req_data_in;
  logic [1:0]  req_tag_in;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic [1:0]  out_tag;

  modport master (output req_cmd_in, req_data_in, req_tag_in,
                  input  out_resp, out_data, out_tag);
  modport slave  (input  req_cmd_in, req_data_in, req_tag_in,
                  output out_resp, out_data, out_tag);
endinterface

// File: rtl/calc2_port_responder.sv
// calc2 single-port responder: capture FSM -> in-order FIFO -> one-at-a-time exec unit.
// Optional drop counter enabled by defining CALC2_RESP_DROP_CNT_EN.
module calc2_port_responder #(
  parameter int DEPTH   = 4,
  parameter int ADD_LAT = 2
) (
  input  logic                    c_clk,
  input  logic                    reset,
  calc2_port_responder_if.slave   port,
  output logic [7:0]              drop_cnt
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] ONE      = (AW+1)'(1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [3:0] CMD_ADD = 4'd1, CMD_SUB = 4'd2, CMD_SHL = 4'd5, CMD_SHR = 4'd6;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [1:0]  tag;
    logic [31:0] op1;
    logic [31:0] op2;
  } entry_t;

  typedef enum logic {IDLE, OP2} state_t;

  state_t      state;
  logic [3:0]  cap_cmd;
  logic [1:0]  cap_tag;
  logic [31:0] cap_op1;

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state   <= IDLE;
      cap_cmd <= '0;
      cap_tag <= '0;
      cap_op1 <= '0;
    end else begin
      case (state)
        IDLE: if (port.req_cmd_in != 4'd0) begin
          cap_cmd <= port.req_cmd_in;
          cap_tag <= port.req_tag_in;
          cap_op1 <= port.req_data_in;
          state   <= OP2;
        end
        OP2: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO: the OP2 cycle is the push; a full FIFO still accepts if the head pops on this edge
  entry_t        mem [DEPTH];
  entry_t        new_entry, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, push_ok, pop, full, empty;

  entry_t      ex;
  logic        busy, done;
  logic [4:0]  cnt, load_cnt;

  assign new_entry = '{cmd: cap_cmd, tag: cap_tag, op1: cap_op1, op2: port.req_data_in};
  assign head      = mem[rd_ptr];
  assign push      = (state == OP2);
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign done      = busy && (cnt == 5'd0);
  assign pop       = !empty && (!busy || done);
  assign push_ok   = push && (!full || pop);
  assign load_cnt  = (head.cmd == CMD_ADD || head.cmd == CMD_SUB) ? 5'(ADD_LAT - 1) : 5'd0;

  always_ff @(posedge c_clk) begin
    if (push_ok) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + ONE;
      else if (pop && !push_ok) count <= count - ONE;
    end
  end

  // cnt counts remaining edges; completion is the edge seen with cnt == 0
  always_ff @(posedge c_clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      ex   <= '0;
    end else if (pop) begin
      ex   <= head;
      busy <= 1'b1;
      cnt  <= load_cnt;
    end else if (done) begin
      busy <= 1'b0;
    end else if (busy) begin
      cnt  <= cnt - 5'd1;
    end
  end

  logic [32:0] sum;
  logic [1:0]  res_resp;
  logic [31:0] res_data;

  always_comb begin
    sum      = {1'b0, ex.op1} + {1'b0, ex.op2};
    res_resp = 2'd2;
    res_data = '0;
    case (ex.cmd)
      CMD_ADD: if (!sum[32]) begin
        res_resp = 2'd1;
        res_data = sum[31:0];
      end
      CMD_SUB: if (ex.op2 <= ex.op1) begin
        res_resp = 2'd1;
        res_data = ex.op1 - ex.op2;
      end
      CMD_SHL: begin
        res_resp = 2'd1;
        res_data = ex.op1 << ex.op2[4:0];
      end
      CMD_SHR: begin
        res_resp = 2'd1;
        res_data = ex.op1 >> ex.op2[4:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (reset || !done) begin
      port.out_resp <= '0;
      port.out_data <= '0;
      port.out_tag  <= '0;
    end else begin
      port.out_resp <= res_resp;
      port.out_data <= res_data;
      port.out_tag  <= ex.tag;
    end
  end

`ifdef CALC2_RESP_DROP_CNT_EN
  logic drop;
  assign drop = push && full && !pop;

  always_ff @(posedge c_clk) begin
    if (reset)                            drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hFF)   drop_cnt <= drop_cnt + 8'd1;
  end
`else
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_calc2_port_responder.sv
// Directed bench for calc2_port_responder: ADD_LAT=2 and ADD_LAT=16 instances with a response scoreboard.
module tb_calc2_port_responder;
  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  tag;
    int          cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d2, d16;
  int         cyc = 0;
  int         passed = 0;
  int         total = 0;
  int         seen2 = 0;
  exp_t       q2[$];
  exp_t       q16[$];
  exp_t       m2_e, m16_e;
  logic [7:0] exp_drop;

  calc2_port_responder_if p2();
  calc2_port_responder_if p16();

  calc2_port_responder #(.DEPTH(4), .ADD_LAT(2)) u_lat2 (
    .c_clk(clk), .reset(rst), .port(p2), .drop_cnt(d2));
  calc2_port_responder #(.DEPTH(4), .ADD_LAT(16)) u_lat16 (
    .c_clk(clk), .reset(rst), .port(p16), .drop_cnt(d16));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge two cycles later.
  task automatic send(input bit sel, input logic [3:0] cmd, input logic [1:0] tag,
                      input logic [31:0] a, input logic [31:0] b, input bit want,
                      input logic [1:0] r, input logic [31:0] d, input int delay);
    exp_t e;
    int   e0;
    e0 = cyc + 1;
    if (sel) begin
      p16.req_cmd_in = cmd; p16.req_tag_in = tag; p16.req_data_in = a;
    end else begin
      p2.req_cmd_in = cmd;  p2.req_tag_in = tag;  p2.req_data_in = a;
    end
    if (want) begin
      e = '{resp: r, data: d, tag: tag, cyc: e0 + delay};
      if (sel) q16.push_back(e); else q2.push_back(e);
    end
    @(negedge clk);
    if (sel) begin
      p16.req_cmd_in = 4'd0; p16.req_tag_in = 2'd0; p16.req_data_in = b;
    end else begin
      p2.req_cmd_in = 4'd0;  p2.req_tag_in = 2'd0;  p2.req_data_in = b;
    end
    @(negedge clk);
  endtask

  task automatic drain(input bit sel, input int limit);
    int n;
    n = 0;
    while ((sel ? q16.size() : q2.size()) != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    if ((sel ? q16.size() : q2.size()) != 0) begin
      chk("drain_timeout", 64'(sel ? q16.size() : q2.size()), 64'd0);
      if (sel) q16.delete(); else q2.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (p2.out_resp != 2'd0) begin
      seen2++;
      if (q2.size() == 0) chk("p2_unexpected_resp", 64'(p2.out_resp), 64'd0);
      else begin
        m2_e = q2.pop_front();
        chk("p2_resp", 64'(p2.out_resp), 64'(m2_e.resp));
        chk("p2_data", 64'(p2.out_data), 64'(m2_e.data));
        chk("p2_tag",  64'(p2.out_tag),  64'(m2_e.tag));
        chk("p2_cycle", 64'(cyc), 64'(m2_e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (p16.out_resp != 2'd0) begin
      if (q16.size() == 0) chk("p16_unexpected_resp", 64'(p16.out_resp), 64'd0);
      else begin
        m16_e = q16.pop_front();
        chk("p16_resp", 64'(p16.out_resp), 64'(m16_e.resp));
        chk("p16_data", 64'(p16.out_data), 64'(m16_e.data));
        chk("p16_tag",  64'(p16.out_tag),  64'(m16_e.tag));
        chk("p16_cycle", 64'(cyc), 64'(m16_e.cyc));
      end
    end
  end

  initial begin
    int seen_before;
`ifdef CALC2_RESP_DROP_CNT_EN
    exp_drop = 8'd1;
`else
    exp_drop = 8'd0;
`endif
    p2.req_cmd_in = '0;  p2.req_tag_in = '0;  p2.req_data_in = '0;
    p16.req_cmd_in = '0; p16.req_tag_in = '0; p16.req_data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_resp", 64'(p2.out_resp), 64'd0);
    chk("rst_data", 64'(p2.out_data), 64'd0);
    chk("rst_tag",  64'(p2.out_tag),  64'd0);
    chk("rst_drop", 64'(d2), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // add, then confirm the response lasts exactly one cycle
    send(0, 4'd1, 2'd1, 32'h30, 32'h20, 1, 2'd1, 32'h50, 4);
    drain(0, 20);
    chk("add_one_cycle", 64'(p2.out_resp), 64'd0);

    send(0, 4'd1, 2'd2, 32'hFFFF_FFFF, 32'h1, 1, 2'd2, 32'h0, 4);
    send(0, 4'd1, 2'd3, 32'hFFFF_FFFE, 32'h1, 1, 2'd1, 32'hFFFF_FFFF, 4);
    drain(0, 20);

    send(0, 4'd2, 2'd0, 32'h10, 32'h20, 1, 2'd2, 32'h0, 4);
    send(0, 4'd2, 2'd3, 32'h20, 32'h10, 1, 2'd1, 32'h10, 4);
    send(0, 4'd2, 2'd1, 32'h77, 32'h77, 1, 2'd1, 32'h0, 4);
    drain(0, 20);

    send(0, 4'd5, 2'd1, 32'h1, 32'h24, 1, 2'd1, 32'h10, 3);
    send(0, 4'd6, 2'd2, 32'h8000_0000, 32'd31, 1, 2'd1, 32'h1, 3);
    send(0, 4'd3, 2'd0, 32'h5, 32'h6, 1, 2'd2, 32'h0, 3);
    send(0, 4'd6, 2'd3, 32'hA5A5_0000, 32'h20, 1, 2'd1, 32'hA5A5_0000, 3);
    send(0, 4'd15, 2'd2, 32'h1, 32'h1, 1, 2'd2, 32'h0, 3);
    drain(0, 20);

    // six back-to-back adds into a DEPTH=4 FIFO on the long-latency instance
    for (int i = 0; i < 6; i++)
      send(1, 4'd1, 2'(i % 4), 32'(i * 256), 32'h1, (i < 5), 2'd1, 32'(i * 256 + 1), 18 + 14 * i);
    chk("drop_cnt_mid", 64'(d16), 64'(exp_drop));
    drain(1, 120);
    chk("drop_cnt_end", 64'(d16), 64'(exp_drop));

    // reset while exec busy and a second request queued
    send(0, 4'd1, 2'd1, 32'h1, 32'h2, 0, 2'd0, 32'h0, 0);
    send(0, 4'd1, 2'd2, 32'h3, 32'h4, 0, 2'd0, 32'h0, 0);
    seen_before = seen2;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_resp", 64'(p2.out_resp), 64'd0);
    chk("mid_rst_data", 64'(p2.out_data), 64'd0);
    chk("mid_rst_tag",  64'(p2.out_tag),  64'd0);
    chk("mid_rst_drop16", 64'(d16), 64'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("no_resp_after_rst", 64'(seen2 - seen_before), 64'd0);

    send(0, 4'd1, 2'd2, 32'h1, 32'h1, 1, 2'd1, 32'h2, 4);
    drain(0, 20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
